weight_update_ctrl: RTL and testbench

- Master-side sequencer for the N-lane weight RAM, which has a 65-entry x 10-bit store, an N-word burst port, and an In-driven LFSR randomise mode.
- Runs two jobs, each on a single request:
  - Randomise: hold RAM In high for exactly 65 cycles.
  - Update: read-modify-write sweep of the first NUM_WORDS entries in N-word bursts. Each burst adds one streamed signed delta vector with saturation.
- Sits between the training datapath (delta producer) and the weight RAM.

---
 rtl/weight_pkg.sv | 15 +
 rtl/sat_add_w.sv | 14 +
 rtl/weight_update_ctrl.sv | 89 ++++++++
 tb/tb_weight_update_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// weight_pkg: shared widths, weight type and controller state encoding
package weight_pkg;
    localparam int W_WIDTH    = 10;
    localparam int ADDR_WIDTH = 7;
    localparam int RAM_DEPTH  = 65;
    typedef logic signed [W_WIDTH-1:0] weight_t;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RD   = 3'd2,
        DW   = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5
    } ctrl_state_t;
endpackage

// File: rtl/sat_add_w.sv
// sat_add_w: 10-bit signed add clamped to [-512, 511]
module sat_add_w
    import weight_pkg::*;
(
    input  logic signed [W_WIDTH-1:0] a,
    input  logic signed [W_WIDTH-1:0] b,
    output logic signed [W_WIDTH-1:0] y
);
    logic signed [W_WIDTH:0] sum;
    always_comb begin
        sum = {a[W_WIDTH-1], a} + {b[W_WIDTH-1], b};
        y = (sum[W_WIDTH] != sum[W_WIDTH-1]) ? (sum[W_WIDTH] ? 10'sh200 : 10'sh1FF) : sum[W_WIDTH-1:0];
    end
endmodule

// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl: sequences weight RAM randomise and burst read-modify-write updates
module weight_update_ctrl
    import weight_pkg::*;
#(
    parameter int N           = 10,
    parameter int NUM_WORDS   = 60,
    parameter int INIT_CYCLES = 65
) (
    input  logic                   Clock,
    input  logic                   Rst,
    input  logic                   start,
    input  logic                   init_req,
    input  logic [N*W_WIDTH-1:0]   delta,
    input  logic                   delta_valid,
    output logic                   delta_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_In,
    output logic                   ram_WE,
    output logic [ADDR_WIDTH-1:0]  ram_Address,
    output logic [N*W_WIDTH-1:0]   ram_D,
    input  logic [N*W_WIDTH-1:0]   ram_Q
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - N);
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    ctrl_state_t state, nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [7:0] init_cnt;
    logic [N*W_WIDTH-1:0] sum;
    logic accept;
    assign accept = (state == DW) && delta_ready && delta_valid;
    for (genvar i = 0; i < N; i++) begin : g_lane
        sat_add_w u_add (
            .a(ram_Q[i*W_WIDTH +: W_WIDTH]),
            .b(delta[i*W_WIDTH +: W_WIDTH]),
            .y(sum[i*W_WIDTH +: W_WIDTH])
        );
    end
    always_comb begin
        nxt = state;
        base_nxt = base;
        case (state)
            IDLE: begin
                if (init_req) nxt = INIT;
                else if (start) begin
                    nxt = RD;
                    base_nxt = '0;
                end
            end
            INIT: nxt = (init_cnt == INIT_LAST) ? FIN : INIT;
            RD: nxt = DW;
            DW: nxt = accept ? WR : DW;
            WR: begin
                if (base == LAST) nxt = FIN;
                else begin
                    nxt = RD;
                    base_nxt = base + ADDR_WIDTH'(N);
                end
            end
            default: nxt = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            base <= '0;
            init_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ram_In <= 1'b0;
            ram_WE <= 1'b0;
            delta_ready <= 1'b0;
            ram_Address <= '0;
            ram_D <= '0;
        end else begin
            state <= nxt;
            base <= base_nxt;
            init_cnt <= (state == INIT) ? init_cnt + 8'd1 : '0;
            busy <= nxt inside {INIT, RD, DW, WR};
            done <= nxt == FIN;
            ram_In <= nxt == INIT;
            ram_WE <= nxt == WR;
            delta_ready <= nxt == DW;
            ram_Address <= (nxt inside {RD, DW, WR}) ? base_nxt : '0;
            if (accept) ram_D <= sum;
        end
    end
endmodule

// File: tb/tb_weight_update_ctrl.sv
// tb_weight_update_ctrl: RAM model plus reference checks for the weight update controller
module tb_weight_update_ctrl;
    localparam int N = 10;
    localparam int NW = 60;
    localparam int DEPTH = 65;
    localparam int BURSTS = NW / N;
    typedef struct {
        int q;
        int d;
        int e;
    } vec_t;
    logic Clock = 1'b0;
    logic Rst = 1'b0;
    logic start = 1'b0;
    logic init_req = 1'b0;
    logic delta_valid = 1'b1;
    logic [N*10-1:0] delta = '0;
    logic delta_ready, busy, done, ram_In, ram_WE;
    logic [6:0] ram_Address;
    logic [N*10-1:0] ram_D;
    logic [N*10-1:0] ram_Q = '0;
    logic signed [9:0] mem [DEPTH];
    logic signed [9:0] pre [DEPTH];
    logic signed [9:0] dv [BURSTS][N];
    int exp_mem [DEPTH];
    logic load = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl [N];

    weight_update_ctrl #(.N(N), .NUM_WORDS(NW), .INIT_CYCLES(65)) dut (
        .Clock(Clock), .Rst(Rst), .start(start), .init_req(init_req),
        .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .busy(busy), .done(done), .ram_In(ram_In), .ram_WE(ram_WE),
        .ram_Address(ram_Address), .ram_D(ram_D), .ram_Q(ram_Q)
    );

    always #5 Clock = ~Clock;

    // weight RAM: registered read of N words at Address, write when WE
    always @(posedge Clock) begin
        if (load) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= pre[j];
        end else if (ram_WE) begin
            for (int i = 0; i < N; i++)
                if (int'(ram_Address) + i < DEPTH) mem[int'(ram_Address) + i] <= ram_D[i*10 +: 10];
        end else begin
            for (int i = 0; i < N; i++)
                ram_Q[i*10 +: 10] <= (int'(ram_Address) + i < DEPTH) ? mem[int'(ram_Address) + i] : 10'd0;
        end
    end

    function automatic int sat(input int v);
        return v > 511 ? 511 : (v < -512 ? -512 : v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge Clock);
        load = 1'b1;
        @(negedge Clock);
        load = 1'b0;
    endtask

    task automatic model_exp();
        for (int j = 0; j < DEPTH; j++)
            exp_mem[j] = (j < NW) ? sat(int'(pre[j]) + int'(dv[j / N][j % N])) : int'(pre[j]);
    endtask

    task automatic check_mem(input string tag);
        for (int j = 0; j < DEPTH; j++) chk($sformatf("%s_mem%0d", tag, j), int'(mem[j]), exp_mem[j]);
    endtask

    task automatic run_sweep(input string tag, input int stall_b, input int stall_len, input bit rnd);
        int b, sc, stalls, done_c, viol, stallbad;
        bit prev_we;
        int weq[$];
        sc = 0; stalls = 0; done_c = -1; viol = 0; stallbad = 0; prev_we = 0;
        @(negedge Clock);
        start = 1'b1;
        delta_valid = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 400; c++) begin
            @(negedge Clock);
            start = 1'b0;
            if (ram_WE) weq.push_back(int'(ram_Address));
            if (ram_WE && prev_we) viol++;
            prev_we = ram_WE;
            if (done) begin
                done_c = c;
                break;
            end
            delta_valid = 1'b1;
            if (delta_ready) begin
                b = int'(ram_Address) / N;
                if (b < BURSTS) for (int i = 0; i < N; i++) delta[i*10 +: 10] = dv[b][i];
                if (ram_WE) viol++;
                if (rnd) delta_valid = 1'($urandom_range(0, 1));
                else if (b == stall_b && sc < stall_len) begin
                    delta_valid = 1'b0;
                    sc++;
                    if (int'(ram_Address) != stall_b * N) stallbad++;
                end
                if (!delta_valid) stalls++;
            end
        end
        delta_valid = 1'b1;
        chk({tag, "_done_cycle"}, done_c, 3 * BURSTS + 1 + stalls);
        chk({tag, "_we_count"}, weq.size(), BURSTS);
        for (int k = 0; k < weq.size() && k < BURSTS; k++) chk($sformatf("%s_we_addr%0d", tag, k), weq[k], k * N);
        chk({tag, "_we_viol"}, viol, 0);
        chk({tag, "_stall_addr"}, stallbad, 0);
        @(negedge Clock);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int in_hi, dones, act, done_c, to;
        tbl[0] = '{500, 20, 511};    tbl[1] = '{-500, -30, -512};
        tbl[2] = '{-1, 1, 0};        tbl[3] = '{5, 3, 8};
        tbl[4] = '{511, 1, 511};     tbl[5] = '{-512, -1, -512};
        tbl[6] = '{0, 0, 0};         tbl[7] = '{100, -200, -100};
        tbl[8] = '{511, -511, 0};    tbl[9] = '{-300, -300, -512};
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in", int'(ram_In), 0);
        chk("rst_we", int'(ram_WE), 0);
        chk("rst_addr", int'(ram_Address), 0);
        chk("rst_ready", int'(delta_ready), 0);
        chk("rst_d_nonzero", int'(ram_D != '0), 0);
        @(negedge Clock);
        Rst = 1'b1;
        // normal sweep: 5 everywhere, +3
        for (int j = 0; j < DEPTH; j++) pre[j] = 10'sd5;
        for (int b = 0; b < BURSTS; b++) for (int i = 0; i < N; i++) dv[b][i] = 10'sd3;
        load_mem();
        run_sweep("norm", -1, 0, 0);
        for (int j = 0; j < DEPTH; j++) exp_mem[j] = (j < NW) ? 8 : 5;
        check_mem("norm");
        // stall 7 cycles in burst at address 10
        for (int j = 0; j < DEPTH; j++) pre[j] = mem[j];
        load_mem();
        run_sweep("stall", 1, 7, 0);
        for (int j = 0; j < DEPTH; j++) exp_mem[j] = (j < NW) ? 11 : 5;
        check_mem("stall");
        // saturation table
        for (int j = 0; j < DEPTH; j++) pre[j] = (j < NW) ? 10'(tbl[j % N].q) : 10'sd5;
        for (int b = 0; b < BURSTS; b++) for (int i = 0; i < N; i++) dv[b][i] = 10'(tbl[i].d);
        load_mem();
        run_sweep("sat", -1, 0, 0);
        for (int j = 0; j < DEPTH; j++) exp_mem[j] = (j < NW) ? tbl[j % N].e : 5;
        check_mem("sat");
        // random contents, deltas and handshake stalls
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < DEPTH; j++) pre[j] = 10'($urandom_range(0, 1023));
            for (int b = 0; b < BURSTS; b++) for (int i = 0; i < N; i++) dv[b][i] = 10'($urandom_range(0, 1023));
            load_mem();
            model_exp();
            run_sweep($sformatf("rnd%0d", r), -1, 0, 1);
            check_mem($sformatf("rnd%0d", r));
        end
        // randomise job with simultaneous start, and a start during INIT
        in_hi = 0; dones = 0; act = 0; done_c = -1;
        @(negedge Clock);
        init_req = 1'b1;
        start = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clock);
            init_req = 1'b0;
            start = (c == 10);
            if (ram_In) in_hi++;
            if (ram_WE || delta_ready) act++;
            if (done) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
        end
        start = 1'b0;
        chk("init_in_cycles", in_hi, 65);
        chk("init_done_cycle", done_c, 66);
        chk("init_done_count", dones, 1);
        chk("init_rdwr_activity", act, 0);
        chk("init_busy_after", int'(busy), 0);
        // reset while waiting in DW
        @(negedge Clock);
        start = 1'b1;
        delta_valid = 1'b0;
        @(negedge Clock);
        start = 1'b0;
        to = 0;
        while (!delta_ready && to < 10) begin
            @(negedge Clock);
            to++;
        end
        chk("rstdw_reach_dw", int'(delta_ready), 1);
        Rst = 1'b0;
        #1;
        chk("rstdw_busy", int'(busy), 0);
        chk("rstdw_ready", int'(delta_ready), 0);
        chk("rstdw_we", int'(ram_WE), 0);
        chk("rstdw_in", int'(ram_In), 0);
        chk("rstdw_done", int'(done), 0);
        chk("rstdw_addr", int'(ram_Address), 0);
        chk("rstdw_d_nonzero", int'(ram_D != '0), 0);
        @(negedge Clock);
        Rst = 1'b1;
        delta_valid = 1'b1;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        chk("restart_addr", int'(ram_Address), 0);
        chk("restart_we", int'(ram_WE), 0);
        chk("restart_busy", int'(busy), 1);
        to = 0;
        while (!done && to < 100) begin
            @(negedge Clock);
            to++;
        end
        chk("restart_done", int'(done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
